// File: rtl/kitchen_timer_pkg.sv
// Shared types, constants and mm:ss step arithmetic for the kitchen timer.
package kitchen_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int             VAL_W      = 6;
    localparam logic [VAL_W-1:0] MAX_VAL  = 6'd59;
    localparam int             PRESCALE_W = 27;

    typedef struct packed {
        logic [VAL_W-1:0] min_v;
        logic [VAL_W-1:0] sec_v;
        logic             done;
    } step_t;

    function automatic logic [VAL_W-1:0] clamp_val(input logic [VAL_W-1:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    // Counting down finishes on reaching 00:00; counting up finishes on a step taken at 59:59.
    function automatic step_t count_step(input logic [VAL_W-1:0] m,
                                         input logic [VAL_W-1:0] s,
                                         input logic             up);
        step_t r;
        r.min_v = m;
        r.sec_v = s;
        r.done  = 1'b0;
        if (up) begin
            if (m == MAX_VAL && s == MAX_VAL) begin
                r.done = 1'b1;
            end else if (s < MAX_VAL) begin
                r.sec_v = s + 1'b1;
            end else begin
                r.sec_v = '0;
                r.min_v = m + 1'b1;
            end
        end else begin
            if (s != '0) begin
                r.sec_v = s - 1'b1;
            end else if (m != '0) begin
                r.min_v = m - 1'b1;
                r.sec_v = MAX_VAL;
            end
            r.done = (r.min_v == '0) && (r.sec_v == '0);
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to the count-step tick; the terminal count follows the zippy level.
module tick_prescaler
    import kitchen_timer_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int ZIPPY_DIV = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic zippy,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] T_SLOW = PRESCALE_W'(CLK_HZ - 1);
    localparam logic [PRESCALE_W-1:0] T_FAST = PRESCALE_W'(CLK_HZ / ZIPPY_DIV - 1);

    logic [PRESCALE_W-1:0] r_count;
    logic                  r_tick;
    logic [PRESCALE_W-1:0] w_term;

    assign w_term = zippy ? T_FAST : T_SLOW;

    // NOTE: sequential state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (clr) begin
                r_count <= '0;
            end else if (en) begin
                // >= rather than == so a switch to the fast rate past its terminal still wraps.
                if (r_count >= w_term) begin
                    r_count <= '0;
                    r_tick  <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/kitchen_timer_ctrl.sv
// Set/run/pause/done sequencing and mm:ss counters for the kitchen timer.
module kitchen_timer_ctrl
    import kitchen_timer_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int ZIPPY_DIV = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             minbtn,
    input  logic             secbtn,
    input  logic             start,
    input  logic             pause,
    input  logic             count_up,
    input  logic             zippy,
    input  logic [VAL_W-1:0] timesetter,
    output logic [VAL_W-1:0] min_val,
    output logic [VAL_W-1:0] sec_val,
    output logic             running,
    output logic             zled,
    output logic             tick
);

    state_t           r_state, w_state_nxt;
    logic [VAL_W-1:0] r_min, r_sec, w_min_nxt, w_sec_nxt;
    logic             r_running, r_zled;
    logic             w_tick, w_clr, w_en;
    step_t            w_step;

    assign w_en   = (r_state == ST_RUN);
    assign w_step = count_step(r_min, r_sec, count_up);

    tick_prescaler #(
        .CLK_HZ    (CLK_HZ),
        .ZIPPY_DIV (ZIPPY_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (w_en),
        .clr   (w_clr),
        .zippy (zippy),
        .tick  (w_tick)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_clr       = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_tick) begin
                    w_min_nxt = w_step.min_v;
                    w_sec_nxt = w_step.sec_v;
                end
                if (w_tick && w_step.done) begin
                    w_state_nxt = ST_DONE;
                end else if (pause) begin
                    w_state_nxt = ST_PAUSED;
                end
            end
            ST_IDLE, ST_PAUSED: begin
                if (pause && r_state == ST_PAUSED) begin
                    w_state_nxt = ST_RUN;
                end else if (start) begin
                    w_state_nxt = ST_RUN;
                    w_clr       = 1'b1;
                end else begin
                    if (minbtn) w_min_nxt = clamp_val(timesetter);
                    if (secbtn) w_sec_nxt = clamp_val(timesetter);
                end
            end
            ST_DONE: begin
                w_clr = 1'b1;
                if (start) begin
                    w_state_nxt = ST_IDLE;
                end else if (minbtn || secbtn) begin
                    w_state_nxt = ST_IDLE;
                    if (minbtn) w_min_nxt = clamp_val(timesetter);
                    if (secbtn) w_sec_nxt = clamp_val(timesetter);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_min     <= '0;
            r_sec     <= '0;
            r_running <= 1'b0;
            r_zled    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_min     <= w_min_nxt;
            r_sec     <= w_sec_nxt;
            r_running <= (w_state_nxt == ST_RUN);
            r_zled    <= (w_state_nxt == ST_DONE);
        end
    end

    assign min_val = r_min;
    assign sec_val = r_sec;
    assign running = r_running;
    assign zled    = r_zled;
    assign tick    = w_tick;

endmodule

// File: doc/kitchen_timer_ctrl.md
Name: kitchen_timer_ctrl

Overview:
Control FSM and mm:ss counter core for the kitchen timer. It takes debounced single-cycle button pulses and slide-switch levels, and sequences set, run, pause and done. It produces the minute/second values consumed by the seven-segment driver and the zled alarm output. It sits between the input conditioning (debounce/one-shot) and the display mux.

Parameters:
CLK_HZ, 100000000, clk cycles per real second
ZIPPY_DIV, 100, speed-up factor when zippy=1; tick period = CLK_HZ/ZIPPY_DIV cycles
MAX_VAL, 59, maximum minute and second value

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-low reset
minbtn  in  1  one-cycle pulse: load minutes from timesetter
secbtn  in  1  one-cycle pulse: load seconds from timesetter
start  in  1  one-cycle pulse: start/resume; acknowledge done
pause  in  1  one-cycle pulse: toggle RUN/PAUSED
count_up  in  1  level: 1 = count up, 0 = count down; sampled at each tick
zippy  in  1  level: 1 = fast tick rate
timesetter  in  6  switch value, binary 0..63
min_val  out  6  current minutes, binary 0..59
sec_val  out  6  current seconds, binary 0..59
running  out  1  high in RUN
zled  out  1  high in DONE
tick  out  1  one-cycle pulse at each count step (RUN only)

Behaviour:
- Reset: reset=0 at a clk edge puts state IDLE, min_val=0, sec_val=0, prescaler=0, running=0, zled=0, tick=0. Reset overrides all inputs and applies mid-run.
- States: IDLE=0, RUN=1, PAUSED=2, DONE=3. All outputs are registered.
- Loads are allowed in IDLE, PAUSED and DONE:
  - minbtn: min_val <= min(timesetter, MAX_VAL).
  - secbtn: sec_val <= min(timesetter, MAX_VAL).
  - Both pulses in the same cycle load both fields.
  - A load in DONE moves to IDLE.
  - Loads are ignored in RUN.
- start:
  - IDLE/PAUSED -> RUN, and the prescaler clears.
  - DONE -> IDLE with values held.
  - Ignored in RUN.
- pause: RUN -> PAUSED; PAUSED -> RUN with the prescaler held, not cleared. Ignored in IDLE/DONE.
- Same-cycle priority: pause > start > loads. A load that arrives with start in IDLE/PAUSED is dropped.
- Prescaler: counts only in RUN.
  - Terminal T = CLK_HZ-1 when zippy=0, else CLK_HZ/ZIPPY_DIV-1.
  - When prescaler >= T, it clears and tick pulses the next cycle. The >= compare covers a zippy change mid-count.
  - The first tick after start arrives T+1 cycles after the start pulse is sampled.
- Count-down step, on tick with count_up=0:
  - If sec>0, sec is decremented.
  - Else if min>0, min is decremented and sec=59.
  - If the resulting value is 00:00, go to DONE in the same update.
- Count-up step, on tick with count_up=1:
  - If sec<59, sec is incremented.
  - Else sec=0 and min is incremented.
  - At 59:59 the values hold and the state goes to DONE in the same update.
- Start at boundary: start with 00:00 and count_up=0 enters RUN; the first tick goes directly to DONE and values hold at 00:00.
- Direction change mid-run takes effect at the next tick; no glitch on min_val/sec_val.
- running = (state==RUN); zled = (state==DONE).
- DONE holds values and clears the prescaler.

Decomposition:
- kitchen_timer_pkg holds:
  - state typedef and encodings (IDLE/RUN/PAUSED/DONE);
  - MAX_VAL=59;
  - the 27-bit prescaler width constant, sized for CLK_HZ=1e8.
- One sub-module, tick_prescaler.
  - Inputs: clk, reset, en, clr, zippy.
  - Output: tick.
  - Parameters: CLK_HZ, ZIPPY_DIV.
- The FSM and the mm:ss counters stay in kitchen_timer_ctrl.

Test Plan:
All scenarios use CLK_HZ=100, ZIPPY_DIV=10.
- Reset mid-run: load 01:30, start, wait 250 cycles, then pulse reset=0 for one cycle -> next cycle min_val=0, sec_val=0, state IDLE, zled=0, tick=0.
- Load clamp: timesetter=59 with minbtn, then timesetter=63 with secbtn -> min_val=59, sec_val=59. A load pulsed while in RUN -> values unchanged.
- Count-down to done: load 00:03, count_up=0, start -> ticks at cycles 100, 200, 300; values go 2, 1, 0. At the tick that reaches 00:00, zled=1 and running=0. Then start -> IDLE, zled=0, values 00:00.
- Count-up with minute rollover and zippy: load 00:58, count_up=1, zippy=1, start -> ticks every 10 cycles; values go 00:59, 01:00, 01:01. Then zippy=0 -> the next tick comes 100 cycles later.
- Count-up terminal: load 59:58 and count up -> after 2 ticks values are 59:59 and zled=1; further time yields no ticks and values hold.
- Pause/resume and priority:
  - Run from 00:10 down to 00:07, then pulse pause -> PAUSED, values hold for 500 cycles, no tick.
  - Pulse pause again -> RUN resumes with the prescaler retained.
  - In PAUSED, start and minbtn in the same cycle -> RUN, and min_val is not loaded.
